// File: rtl/core_sequencer_if.sv
// Memory bus between the sequencer and instruction/data memory.
// Request and qualifiers flow out; completion flows back.
interface core_sequencer_if #(
  parameter int WORD_SIZE = 32
);
  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic                 mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output mem_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle core control FSM: fetch, decode, execute, memory/MMIO
// access and writeback, with wait timeouts and absorbing fault states.
module core_sequencer #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   NUM_MMIO  = 2,
  parameter logic [WORD_SIZE-1:0] MMIO_BASE = 32'h00070000,
  parameter logic [WORD_SIZE-1:0] MMIO_SPAN = 32'h00002000,
  parameter int                   TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_mode,
  input  logic                 decode_error,
  input  logic                 halt_instr,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 rd_valid,
  input  logic                 take_target,
  input  logic [WORD_SIZE-1:0] target_pc,
  input  logic [WORD_SIZE-1:0] alu_addr,
  input  logic [1:0]           access_size,
  core_sequencer_if.master     mem,
  output logic [3:0]           state,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 ir_load,
  output logic                 alu_latch,
  output logic                 reg_we,
  output logic [NUM_MMIO-1:0]  mmio_sel,
  output logic                 mmio_we,
  output logic [31:0]          instr_count,
  output logic                 fault
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_WFETCH = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_WMEM   = 4'd6,
    S_WB     = 4'd7,
    S_HALT   = 4'd9,
    S_TERR   = 4'd12,
    S_MERR   = 4'd13,
    S_DERR   = 4'd14,
    S_FERR   = 4'd15
  } state_t;

  localparam int XW = WORD_SIZE + 4;

  state_t               r_state;
  state_t               w_next;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_addr;
  logic                 r_we;
  logic [NUM_MMIO-1:0]  r_sel;
  logic [7:0]           r_cnt;
  logic [31:0]          r_icnt;
  logic [NUM_MMIO-1:0]  w_sel;
  logic                 w_hit;
  logic                 w_misal;
  logic                 w_tmo;
  logic [XW-1:0]        w_xaddr;

  // Widened compare so the last window end cannot wrap past zero
  function automatic logic [XW-1:0] win_lo(input int k);
    return XW'(MMIO_BASE) + XW'(k) * XW'(MMIO_SPAN);
  endfunction

  assign w_xaddr = {4'b0, alu_addr};

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_MMIO; k++) begin
      if (w_xaddr >= win_lo(k) && w_xaddr < win_lo(k + 1))
        w_sel[k] = 1'b1;
    end
  end

  assign w_hit = |w_sel;

  always_comb begin
    unique case (access_size)
      2'd0:    w_misal = 1'b1;
      2'd1:    w_misal = 1'b0;
      2'd2:    w_misal = alu_addr[0];
      default: w_misal = |alu_addr[1:0];
    endcase
  end

  assign w_tmo = (r_cnt + 8'd1) == 8'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem.mem_req = 1'b0;
    ir_load   = 1'b0;
    alu_latch = 1'b0;
    reg_we    = 1'b0;
    mmio_we   = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_WFETCH;
      S_WFETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_load = 1'b1;
          w_next  = S_DECODE;
        end else if (w_tmo) begin
          w_next = S_TERR;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        alu_latch = 1'b1;
        if (halt_instr)              w_next = S_HALT;
        else if (decode_error)       w_next = S_DERR;
        else if (is_load | is_store) w_next = S_MEM;
        else                         w_next = S_WB;
      end
      S_MEM: begin
        if (w_misal)    w_next = S_MERR;
        else if (w_hit) w_next = S_WB;
        else            w_next = S_WMEM;
      end
      S_WMEM: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) w_next = S_WB;
        else if (w_tmo)  w_next = S_TERR;
      end
      S_WB: begin
        reg_we  = rd_valid & ~is_store;
        mmio_we = is_store & (|r_sel);
        w_next  = step_mode ? S_IDLE : S_FETCH;
      end
      S_HALT, S_TERR, S_MERR, S_DERR, S_FERR: w_next = r_state;
      default: w_next = S_FERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_addr <= '0;
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_cnt  <= '0;
      r_icnt <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_addr <= r_pc;
          r_we   <= 1'b0;
          r_cnt  <= '0;
        end
        S_WFETCH, S_WMEM: begin
          if (!mem.mem_ack) r_cnt <= r_cnt + 8'd1;
        end
        S_MEM: begin
          if (!w_misal) begin
            if (w_hit) begin
              r_sel <= w_sel;
            end else begin
              r_addr <= alu_addr;
              r_we   <= is_store;
              r_cnt  <= '0;
            end
          end
        end
        S_WB: begin
          r_pc   <= take_target ? target_pc : r_pc + WORD_SIZE'(4);
          r_icnt <= r_icnt + 32'd1;
          r_sel  <= '0;
          r_we   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign state        = r_state;
  assign pc           = r_pc;
  assign mem.mem_addr = r_addr;
  assign mem.mem_we   = r_we;
  assign mmio_sel     = r_sel;
  assign instr_count  = r_icnt;
  assign fault        = r_state inside {S_TERR, S_MERR, S_DERR, S_FERR};

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a per-instruction model builds the expected
// state trace and outputs from the sequencing rules, then drives and checks.
module tb_core_sequencer;

  localparam int          TMO  = 15;
  localparam longint      BASE = 64'h70000;
  localparam longint      SPAN = 64'h2000;
  localparam longint      NUM  = 2;
  localparam int S_IDLE = 0, S_FETCH = 1, S_WF = 2, S_DEC = 3, S_EX = 4;
  localparam int S_MA = 5, S_WM = 6, S_WB = 7, S_HALT = 9;
  localparam int S_TE = 12, S_ME = 13, S_DE = 14;

  typedef struct {
    bit          halt, derr, ld, st, rdv, take;
    logic [31:0] tgt, addr;
    logic [1:0]  size;
    int          fd, md;
  } ins_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0, step_mode = 0;
  logic        decode_error = 0, halt_instr = 0;
  logic        is_load = 0, is_store = 0, rd_valid = 0, take_target = 0;
  logic [31:0] target_pc = 0, alu_addr = 0;
  logic [1:0]  access_size = 0;
  logic [3:0]  state;
  logic [31:0] pc, instr_count;
  logic        ir_load, alu_latch, reg_we, mmio_we, fault;
  logic [1:0]  mmio_sel;

  int total = 0;
  int bad   = 0;
  int          m_state;
  logic [31:0] m_pc, m_cnt;

  core_sequencer_if #(.WORD_SIZE(32)) bus ();

  core_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
    .decode_error(decode_error), .halt_instr(halt_instr),
    .is_load(is_load), .is_store(is_store), .rd_valid(rd_valid),
    .take_target(take_target), .target_pc(target_pc),
    .alu_addr(alu_addr), .access_size(access_size), .mem(bus),
    .state(state), .pc(pc), .ir_load(ir_load), .alu_latch(alu_latch),
    .reg_we(reg_we), .mmio_sel(mmio_sel), .mmio_we(mmio_we),
    .instr_count(instr_count), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int win_of(input logic [31:0] a);
    longint x = longint'(a);
    if (x >= BASE && x < BASE + NUM * SPAN) return int'((x - BASE) / SPAN);
    return -1;
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] bytes;
    if (s == 2'd0) return 1'b1;
    bytes = 32'd1 << (s - 2'd1);
    return (a % bytes) != 0;
  endfunction

  function automatic ins_t alu_ins();
    ins_t t;
    t.halt = 0; t.derr = 0; t.ld = 0; t.st = 0; t.rdv = 1; t.take = 0;
    t.tgt = 0; t.addr = 0; t.size = 2'd3; t.fd = 0; t.md = 0;
    return t;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1; start = 1'($urandom % 2); bus.mem_ack = 1'($urandom % 2);
    @(negedge clk);
    rst = 0; start = 0; bus.mem_ack = 0;
    #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL rst_state got %0d want 0", state); end
    total++;
    if (pc !== 32'd0) begin bad++; $display("FAIL rst_pc got %0h want 0", pc); end
    total++;
    if (instr_count !== 32'd0) begin bad++; $display("FAIL rst_icnt got %0d want 0", instr_count); end
    total++;
    if (bus.mem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got %0h want 0", bus.mem_addr); end
    total++;
    if ({bus.mem_we, bus.mem_req, fault, mmio_sel} !== 5'd0) begin
      bad++; $display("FAIL rst_flags got %b want 00000", {bus.mem_we, bus.mem_req, fault, mmio_sel});
    end
    total++;
    if ({ir_load, alu_latch, reg_we, mmio_we} !== 4'd0) begin
      bad++; $display("FAIL rst_strobes got %b want 0000", {ir_load, alu_latch, reg_we, mmio_we});
    end
    m_state = S_IDLE; m_pc = 0; m_cnt = 0;
  endtask

  task automatic run_instr(input string nm, input ins_t t, input bit step);
    int exp[$];
    int wk, w, nx, last;
    bit win, term, ack_v;
    logic [31:0] pc_n, cnt_n;
    logic [1:0]  sel_e;
    wk = win_of(t.addr); win = 0; term = 0; pc_n = m_pc; cnt_n = m_cnt;
    exp.push_back(m_state);
    if (m_state == S_IDLE) exp.push_back(S_FETCH);
    if (t.fd >= TMO) begin
      repeat (TMO) exp.push_back(S_WF);
      exp.push_back(S_TE); term = 1;
    end else begin
      repeat (t.fd + 1) exp.push_back(S_WF);
      exp.push_back(S_DEC); exp.push_back(S_EX);
      if (t.halt) begin exp.push_back(S_HALT); term = 1; end
      else if (t.derr) begin exp.push_back(S_DE); term = 1; end
      else if (t.ld || t.st) begin
        exp.push_back(S_MA);
        if (misal(t.addr, t.size)) begin exp.push_back(S_ME); term = 1; end
        else if (wk >= 0) win = 1;
        else if (t.md >= TMO) begin
          repeat (TMO) exp.push_back(S_WM);
          exp.push_back(S_TE); term = 1;
        end else repeat (t.md + 1) exp.push_back(S_WM);
      end
      if (!term) begin
        exp.push_back(S_WB);
        pc_n  = t.take ? t.tgt : m_pc + 32'd4;
        cnt_n = m_cnt + 32'd1;
        exp.push_back(step ? S_IDLE : S_FETCH);
      end
    end
    if (term) begin exp.push_back(exp[$]); exp.push_back(exp[$]); end
    sel_e = win ? (2'b01 << wk) : 2'b00;
    halt_instr = t.halt; decode_error = t.derr; is_load = t.ld; is_store = t.st;
    rd_valid = t.rdv; take_target = t.take; target_pc = t.tgt;
    alu_addr = t.addr; access_size = t.size; step_mode = step;
    last = exp.size() - 1;
    for (int i = 0; i <= last; i++) begin
      w = exp[i];
      if (i == last) begin
        #1;
        total++;
        if (state !== 4'(w)) begin bad++; $display("FAIL %s end_state got %0d want %0d", nm, state, w); end
        total++;
        if (fault !== (w >= S_TE)) begin bad++; $display("FAIL %s end_fault got %b want %b", nm, fault, w >= S_TE); end
        total++;
        if (pc !== pc_n) begin bad++; $display("FAIL %s pc got %0h want %0h", nm, pc, pc_n); end
        total++;
        if (instr_count !== cnt_n) begin bad++; $display("FAIL %s icnt got %0d want %0d", nm, instr_count, cnt_n); end
      end else begin
        nx = exp[i + 1];
        start = (w == S_IDLE);
        if (w == S_WF || w == S_WM)
          ack_v = (w == S_WF && nx == S_DEC) || (w == S_WM && nx == S_WB);
        else
          ack_v = 1'($urandom % 2);
        bus.mem_ack = ack_v;
        #1;
        total++;
        if (state !== 4'(w)) begin bad++; $display("FAIL %s state c%0d got %0d want %0d", nm, i, state, w); end
        total++;
        if (bus.mem_req !== (w == S_WF || w == S_WM)) begin
          bad++; $display("FAIL %s mem_req c%0d got %b want %b", nm, i, bus.mem_req, (w == S_WF || w == S_WM));
        end
        total++;
        if ({ir_load, alu_latch, reg_we, mmio_we} !==
            {w == S_WF && ack_v, w == S_EX, w == S_WB && t.rdv && !t.st, w == S_WB && t.st && win}) begin
          bad++; $display("FAIL %s strobes c%0d got %b want %b", nm, i, {ir_load, alu_latch, reg_we, mmio_we},
            {w == S_WF && ack_v, w == S_EX, w == S_WB && t.rdv && !t.st, w == S_WB && t.st && win});
        end
        total++;
        if (mmio_sel !== ((w == S_WB) ? sel_e : 2'b00)) begin
          bad++; $display("FAIL %s mmio_sel c%0d got %b want %b", nm, i, mmio_sel, (w == S_WB) ? sel_e : 2'b00);
        end
        total++;
        if (fault !== (w >= S_TE)) begin bad++; $display("FAIL %s fault c%0d got %b want %b", nm, i, fault, w >= S_TE); end
        if (w == S_WF || w == S_WM) begin
          total++;
          if (bus.mem_addr !== ((w == S_WF) ? m_pc : t.addr) || bus.mem_we !== (w == S_WM && t.st)) begin
            bad++; $display("FAIL %s addr c%0d got %0h/%b want %0h/%b", nm, i, bus.mem_addr, bus.mem_we,
              (w == S_WF) ? m_pc : t.addr, (w == S_WM && t.st));
          end
        end
        @(negedge clk);
      end
    end
    m_state = exp[last]; m_pc = pc_n; m_cnt = cnt_n;
  endtask

  task automatic test_alu();
    ins_t t = alu_ins();
    t.fd = 2;
    run_instr("alu", t, 0);
  endtask

  task automatic test_mmio_store();
    ins_t t = alu_ins();
    t.st = 1; t.addr = 32'h00072004; t.size = 2'd3;
    run_instr("mmio_st", t, 0);
    t.st = 0; t.ld = 1; t.addr = 32'h00070000; t.size = 2'd1;
    run_instr("mmio_ld", t, 0);
  endtask

  task automatic test_misaligned();
    ins_t t = alu_ins();
    t.ld = 1; t.addr = 32'h00000102; t.size = 2'd3;
    run_instr("misal", t, 0);
    test_reset();
  endtask

  task automatic test_timeout();
    ins_t t = alu_ins();
    t.fd = TMO - 1;
    run_instr("ack_last", t, 0);
    t.ld = 1; t.addr = 32'h100; t.md = TMO - 1;
    run_instr("mack_last", t, 0);
    t = alu_ins(); t.fd = TMO + 3;
    run_instr("fetch_tmo", t, 0);
    test_reset();
    t = alu_ins(); t.st = 1; t.addr = 32'h200; t.md = TMO;
    run_instr("mem_tmo", t, 0);
    test_reset();
  endtask

  task automatic test_step_jump();
    ins_t t = alu_ins();
    t.take = 1; t.tgt = 32'h40; t.fd = 1;
    run_instr("step_jmp", t, 1);
    t = alu_ins();
    run_instr("after_jmp", t, 0);
  endtask

  task automatic test_halt();
    ins_t t = alu_ins();
    t.halt = 1; t.derr = 1;
    run_instr("halt", t, 0);
    test_reset();
    t.halt = 0;
    run_instr("dec_err", t, 0);
    test_reset();
  endtask

  task automatic test_boundary();
    ins_t t = alu_ins();
    logic [31:0] a[5];
    a[0] = 32'h0006FFFF; a[1] = 32'h00074000; a[2] = 32'h00073FFF;
    a[3] = 32'h00070000; a[4] = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      t.st = i[0]; t.ld = !i[0]; t.addr = a[i]; t.size = 2'd1; t.md = 1;
      run_instr("bound", t, 0);
    end
  endtask

  task automatic test_midwait_reset();
    start = 1; bus.mem_ack = 0;
    @(negedge clk); start = 0;
    @(negedge clk); @(negedge clk);
    #1;
    total++;
    if (state !== 4'd2) begin bad++; $display("FAIL midwait got %0d want 2", state); end
    test_reset();
  endtask

  task automatic test_random();
    ins_t t;
    int sz;
    for (int n = 0; n < 60; n++) begin
      t = alu_ins();
      t.halt = ($urandom % 20) == 0;
      t.derr = ($urandom % 20) == 0;
      t.rdv  = 1'($urandom % 2);
      t.take = 1'($urandom % 2);
      t.tgt  = $urandom & 32'hFFFF_FFFC;
      case ($urandom % 3)
        0: t.ld = 1;
        1: t.st = 1;
        default: ;
      endcase
      case ($urandom % 6)
        0: t.addr = ($urandom % 1024) * 4;
        1: t.addr = 32'h70000 + $urandom % 32'h2000;
        2: t.addr = 32'h72000 + $urandom % 32'h2000;
        3: t.addr = 32'h74000 + $urandom % 256;
        4: t.addr = $urandom;
        default: t.addr = 32'h6FFFF - $urandom % 16;
      endcase
      sz = $urandom_range(1, 3);
      t.size = 2'(sz);
      if ($urandom % 8 == 0) t.size = 2'($urandom % 4);
      else t.addr = t.addr & ~((32'd1 << (sz - 1)) - 32'd1);
      t.fd = ($urandom % 20 == 0) ? TMO : int'($urandom % 4);
      t.md = ($urandom % 20 == 0) ? TMO : int'($urandom % 4);
      run_instr("rand", t, ($urandom % 4) == 0);
      if (m_state >= S_HALT) test_reset();
    end
  endtask

  initial begin
    bus.mem_ack = 0;
    test_reset();
    test_alu();
    test_mmio_store();
    test_misaligned();
    test_step_jump();
    test_timeout();
    test_halt();
    test_boundary();
    test_midwait_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath/address width.
REQ-002 SHALL have parameter NUM_MMIO, default 2, number of memory-mapped peripheral windows (1..8).
REQ-003 SHALL have parameter MMIO_BASE, default 32'h00070000, start of window 0.
REQ-004 SHALL have parameter MMIO_SPAN, default 32'h00002000, bytes per window; window k = [MMIO_BASE+k*MMIO_SPAN, MMIO_BASE+(k+1)*MMIO_SPAN).
REQ-005 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for mem_ack (1..255).
REQ-006 Ports; one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  leave IDLE, run.
- step_mode  in  1  return to IDLE after each retired instruction.
- decode_error, halt_instr  in  1  from decoder, valid in EXECUTE.
- is_load, is_store, rd_valid  in  1  instruction class, valid EXECUTE..WRITEBACK.
- take_target  in  1  jump or taken branch.
- target_pc  in  WORD_SIZE  jump/branch destination.
- alu_addr  in  WORD_SIZE  effective address, valid in MEM_ACCESS.
- access_size  in  2  1=byte, 2=half, 3=word.
- mem_ack  in  1  memory completion.
- state  out  4  current state encoding.
- pc  out  WORD_SIZE  program counter.
- mem_req, mem_we  out  1  memory request/write qualifier.
- mem_addr  out  WORD_SIZE  memory address.
- ir_load, alu_latch, reg_we  out  1  single-cycle datapath strobes.
- mmio_sel  out  NUM_MMIO  one-hot window select.
- mmio_we  out  1  peripheral write strobe.
- instr_count  out  32  retired-instruction counter.
- fault  out  1  high in any error state.

Function
REQ-007 States/encodings SHALL be: IDLE=0, FETCH=1, WAIT_FETCH=2, DECODE=3, EXECUTE=4, MEM_ACCESS=5, WAIT_MEM=6, WRITEBACK=7, HALT=9, TIMEOUT_ERROR=12, MEM_ERROR=13, DECODE_ERROR=14, FSM_ERROR=15; state output equals current encoding.
REQ-008 IDLE->FETCH when start=1; else stay.
REQ-009 FETCH (1 cycle): mem_addr<=pc, mem_we<=0, timeout counter<=0; ->WAIT_FETCH.
REQ-010 WAIT_FETCH, WAIT_MEM: mem_req=1 combinationally; mem_ack=1 -> advance next edge (WAIT_FETCH->DECODE with ir_load=1 that cycle; WAIT_MEM->WRITEBACK); else counter++; counter==TIMEOUT with no ack -> TIMEOUT_ERROR.
REQ-011 DECODE->EXECUTE, 1 cycle.
REQ-012 EXECUTE: alu_latch=1; priority halt_instr->HALT, decode_error->DECODE_ERROR, is_load|is_store->MEM_ACCESS, else ->WRITEBACK (no memory cycle).
REQ-013 MEM_ACCESS: misaligned (half with addr[0]=1, word with addr[1:0]!=0, access_size=0) -> MEM_ERROR; address in window k<NUM_MMIO -> mmio_sel[k] registered high, ->WRITEBACK; else mem_addr<=alu_addr, mem_we<=is_store, counter<=0, ->WAIT_MEM.
REQ-014 Address at/above MMIO_BASE+NUM_MMIO*MMIO_SPAN SHALL go to memory, not MMIO; window compare SHALL not overflow WORD_SIZE (use WORD_SIZE+4 bits).
REQ-015 WRITEBACK (1 cycle): reg_we=rd_valid&~is_store; mmio_we=is_store&(|mmio_sel); pc<=take_target?target_pc:pc+4 (wraps mod 2^WORD_SIZE); instr_count++ (wraps); then step_mode?IDLE:FETCH; mmio_sel and mem_we clear on exit.
REQ-016 HALT and error states SHALL be absorbing until rst; fault=1 in states 12-15; unused encodings ->FSM_ERROR.
REQ-017 Strobes ir_load, alu_latch, reg_we, mmio_we SHALL each be high exactly one cycle per occurrence, never outside their state.
REQ-018 mem_ack outside wait states SHALL be ignored.

Reset
REQ-019 rst=1 at an edge SHALL, regardless of state (including mid-wait), set state=IDLE, pc=0, mem_addr=0, mem_we=0, mmio_sel=0, counter=0, instr_count=0; mem_req, strobes, fault low next cycle.

Verification
REQ-020 ALU op, ack after 2 cycles, take_target=0: state 1,2,2,2,3,4,7,1; pc 0->4; instr_count 1; reg_we one pulse.
REQ-021 Store alu_addr=32'h00072004 (window 1), word: mmio_sel=2'b10, mmio_we pulse in WRITEBACK, mem_req never high after fetch.
REQ-022 Load alu_addr=32'h00000102 size=3: MEM_ERROR (13), fault=1, pc unchanged.
REQ-023 mem_ack held 0 in WAIT_FETCH: TIMEOUT_ERROR after 15 wait cycles; rst -> IDLE, pc=0.
REQ-024 step_mode=1, jump target 32'h40: after WRITEBACK state=IDLE, pc=32'h40; start -> FETCH with mem_addr=32'h40.
REQ-025 halt_instr=1 with decode_error=1: HALT (9), fault=0, instr_count unchanged.
